// File: rtl/ram_word_access_ctrl.sv
// ram_word_access_ctrl
//
// Master-side sequencer for a banked single-port synchronous RAM. It accepts
// whole-word read/write requests over a valid/ready handshake. Each request
// becomes WORD_BYTES byte-wide RAM beats at consecutive addresses, starting
// with the lowest byte at the lowest address (little-endian). The controller
// then presents the result on a held response handshake. The shared data bus
// is driven only during write beats.
//
// Optional feature: define RAM_CTRL_BOUNDS_CHECK_EN to reject any request
// whose last beat would fall past the top of the address space. A rejected
// request makes no RAM access and answers with resp_err=1. Without the
// macro, beat addresses wrap modulo 2^ADDR_WIDTH and resp_err is tied to 0.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_ready is high only in IDLE
//   req_write             1 = write word, 0 = read word
//   req_addr              address of beat 0
//   req_wdata             write word; beat k = bits [k*DATA_WIDTH +: DATA_WIDTH]
//   resp_valid/resp_ready response handshake; the response is held until accepted
//   resp_rdata            assembled read word (0 for writes)
//   resp_err              request rejected by the bounds check
//   ram_addr, ram_data    RAM address and bidirectional data bus
//   ram_cs, ram_we, ram_oe RAM chip select, write enable, output enable
module ram_word_access_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [WORD_BYTES*DATA_WIDTH-1:0] req_wdata,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [WORD_BYTES*DATA_WIDTH-1:0] resp_rdata,
    output logic                             resp_err,
    output logic [ADDR_WIDTH-1:0]            ram_addr,
    inout  wire  [DATA_WIDTH-1:0]            ram_data,
    output logic                             ram_cs,
    output logic                             ram_we,
    output logic                             ram_oe
);

    localparam int WORD_WIDTH = WORD_BYTES * DATA_WIDTH;
    localparam int CNT_WIDTH  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_RESP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  beat;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic [WORD_WIDTH-1:0] rdata_q;
    logic                  accept;
    logic                  out_of_range;
    logic                  capture_en;
    logic [CNT_WIDTH-1:0]  capture_sel;
    logic [DATA_WIDTH-1:0] write_beat;

    assign accept = req_valid && (state == ST_IDLE);

`ifdef RAM_CTRL_BOUNDS_CHECK_EN
    // One extra bit catches a last-beat address that runs past the top of
    // the address space.
    logic [ADDR_WIDTH:0] end_addr;
    logic                err_q;

    assign end_addr     = {1'b0, req_addr} + (ADDR_WIDTH + 1)'(WORD_BYTES - 1);
    assign out_of_range = end_addr > {1'b0, {ADDR_WIDTH{1'b1}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= out_of_range;
        end
    end

    assign resp_err = err_q;
`else
    assign out_of_range = 1'b0;
    assign resp_err     = 1'b0;
`endif

    // Next-state logic. A rejected request skips the RAM phases entirely.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (out_of_range) begin
                        state_next = ST_RESP;
                    end else if (req_write) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (beat == LAST_BEAT) begin
                    state_next = ST_RESP;
                end
            end
            ST_READ: begin
                if (beat == LAST_BEAT) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The RAM returns data one cycle after it sees the address. At the end
    // of read beat k the bus therefore carries beat k-1. The drain cycle
    // collects the final beat.
    always_comb begin
        capture_en  = 1'b0;
        capture_sel = '0;
        if (state == ST_READ && beat != '0) begin
            capture_en  = 1'b1;
            capture_sel = beat - 1'b1;
        end else if (state == ST_DRAIN) begin
            capture_en  = 1'b1;
            capture_sel = LAST_BEAT;
        end
    end

    always_comb begin
        write_beat = '0;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (beat == CNT_WIDTH'(k)) begin
                write_beat = wdata_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The beat counter stops on the last beat. This keeps the drain cycle
    // on the final address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat      <= '0;
            base_addr <= '0;
            wdata_q   <= '0;
        end else if (accept) begin
            beat      <= '0;
            base_addr <= req_addr;
            wdata_q   <= req_wdata;
        end else if ((state == ST_WRITE || state == ST_READ) && beat != LAST_BEAT) begin
            beat <= beat + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (accept) begin
            rdata_q <= '0;
        end else if (capture_en) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (capture_sel == CNT_WIDTH'(k)) begin
                    rdata_q[k*DATA_WIDTH +: DATA_WIDTH] <= ram_data;
                end
            end
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = rdata_q;

    assign ram_cs   = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
    assign ram_we   = (state == ST_WRITE);
    assign ram_oe   = (state == ST_READ) || (state == ST_DRAIN);
    assign ram_addr = ram_cs ? (base_addr + ADDR_WIDTH'(beat)) : '0;

    // The controller drives the bus only in write beats, so it can never
    // fight the RAM while ram_oe is high.
    assign ram_data = (state == ST_WRITE) ? write_beat : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_word_access_ctrl.sv
// tb_ram_word_access_ctrl
//
// Directed bench for ram_word_access_ctrl with a behavioural synchronous RAM.
// The stimulus pushes the expected response for each request into a
// scoreboard queue. A monitor pops the entry when the response handshake
// completes and checks data, error flag and latency. Under
// RAM_CTRL_BOUNDS_CHECK_EN the wrap-around cases expect rejection instead.
module tb_ram_word_access_ctrl;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int WB = 4;

    typedef struct {
        logic [WB*DW-1:0] rdata;
        logic             err;
        int               due;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [AW-1:0]    req_addr;
    logic [WB*DW-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [WB*DW-1:0] resp_rdata;
    logic             resp_err;
    logic [AW-1:0]    ram_addr;
    wire  [DW-1:0]    ram_data;
    logic             ram_cs;
    logic             ram_we;
    logic             ram_oe;

    logic [DW-1:0]    mem [0:(1<<AW)-1];
    logic [DW-1:0]    rd_q;
    logic             rd_en_q;

    exp_t             sb[$];
    int               tests_run;
    int               tests_failed;
    int               cycle;
    int               cs_cycles;
    int               last_valid_cycle;
    int               last_accept_cycle;
    bit               resp_seen;

    ram_word_access_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .WORD_BYTES(WB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .ram_addr(ram_addr),
        .ram_data(ram_data),
        .ram_cs(ram_cs),
        .ram_we(ram_we),
        .ram_oe(ram_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port synchronous RAM with registered read data. It
    // drives the bus only while output-enabled after a read access.
    always @(posedge clk) begin
        if (ram_cs && ram_we) begin
            mem[ram_addr] <= ram_data;
        end
        rd_q    <= mem[ram_addr];
        rd_en_q <= ram_cs && !ram_we && ram_oe;
    end

    assign ram_data = (rd_en_q && ram_oe) ? rd_q : {DW{1'bz}};

    always @(posedge clk) begin
        cycle = cycle + 1;
        if (ram_cs) begin
            cs_cycles = cs_cycles + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run = tests_run + 1;
        if (actual !== expected) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Waits for the controller to become ready, presents one request for
    // exactly the accept cycle and records the expected response.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                                 input logic [WB*DW-1:0] wdata,
                                 input logic [WB*DW-1:0] exp_rdata,
                                 input logic exp_err);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        last_accept_cycle = cycle;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.due   = cycle + 1 + (exp_err ? 0 : (wr ? WB : WB + 1));
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h5A5A;
        req_wdata = 32'hA5A5_A5A5;
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    // Response monitor: checks latency on first sight and checks content
    // when the response is accepted.
    always @(negedge clk) begin
        if (!rst_n) begin
            resp_seen = 1'b0;
        end else begin
            if (ram_we && ram_oe) begin
                checkOutput("we_oe_overlap", 64'd1, 64'd0);
            end
            if (resp_valid && !resp_seen) begin
                resp_seen        = 1'b1;
                last_valid_cycle = cycle;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    checkOutput("resp_latency", 64'(cycle), 64'(sb[0].due));
                end
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() != 0) begin
                    checkOutput("resp_rdata", 64'(resp_rdata), 64'(sb[0].rdata));
                    checkOutput("resp_err", 64'(resp_err), 64'(sb[0].err));
                    void'(sb.pop_front());
                end
                resp_seen = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cs_before;
        int waited;

        tests_run        = 0;
        tests_failed     = 0;
        cycle            = 0;
        cs_cycles        = 0;
        last_valid_cycle = 0;
        last_accept_cycle = 0;
        resp_seen        = 1'b0;
        rst_n            = 1'b1;
        req_valid        = 1'b0;
        req_write        = 1'b0;
        req_addr         = '0;
        req_wdata        = '0;
        resp_ready       = 1'b1;

        // Power-on reset values.
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst_ram_cs", 64'(ram_cs), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset asserted in the middle of a read, during beat 2.
        applyStimulus(1'b0, 16'h2000, '0, '0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
`ifndef RAM_CTRL_BOUNDS_CHECK_EN
        checkOutput("midread_addr", 64'(ram_addr), 64'h2002);
`else
        checkOutput("midread_addr", 64'(ram_addr), 64'h2002);
`endif
        checkOutput("midread_oe", 64'(ram_oe), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("midrst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("midrst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("midrst_rdata", 64'(resp_rdata), 64'd0);
        checkOutput("midrst_err", 64'(resp_err), 64'd0);
        checkOutput("midrst_ram_addr", 64'(ram_addr), 64'd0);
        checkOutput("midrst_ctrl", 64'({ram_cs, ram_we, ram_oe}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", 64'(req_ready), 64'd1);

        // Write a word, then confirm its byte placement in the RAM.
        applyStimulus(1'b1, 16'h1000, 32'hDDCC_BBAA, '0, 1'b0);
        waitDrain();
        checkOutput("mem_1000", 64'(mem[16'h1000]), 64'hAA);
        checkOutput("mem_1001", 64'(mem[16'h1001]), 64'hBB);
        checkOutput("mem_1002", 64'(mem[16'h1002]), 64'hCC);
        checkOutput("mem_1003", 64'(mem[16'h1003]), 64'hDD);

        // Read back with the response held off for 10 cycles; a stray
        // request during the hold must be ignored.
        resp_ready = 1'b0;
        applyStimulus(1'b0, 16'h1000, '0, 32'hDDCC_BBAA, 1'b0);
        waited = 0;
        while (!resp_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("hold_resp_seen", 64'(resp_valid), 64'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h3000;
        req_wdata = 32'h0102_0304;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 64'(resp_valid), 64'd1);
            checkOutput("hold_rdata", 64'(resp_rdata), 64'hDDCC_BBAA);
            checkOutput("hold_ctrl", 64'({ram_cs, req_ready}), 64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        waitDrain();

        // Back-to-back write then read with resp_ready held high.
        applyStimulus(1'b1, 16'h2000, 32'h1234_5678, '0, 1'b0);
        applyStimulus(1'b0, 16'h2000, '0, 32'h1234_5678, 1'b0);
        checkOutput("b2b_accept_gap", 64'(last_accept_cycle), 64'(last_valid_cycle + 1));
        waitDrain();

        // Word straddling the top of the address space.
        cs_before = cs_cycles;
`ifdef RAM_CTRL_BOUNDS_CHECK_EN
        applyStimulus(1'b1, 16'hFFFE, 32'h4433_2211, '0, 1'b1);
        applyStimulus(1'b0, 16'hFFFE, '0, '0, 1'b1);
        waitDrain();
        checkOutput("bounds_no_cs", 64'(cs_cycles - cs_before), 64'd0);
`else
        applyStimulus(1'b1, 16'hFFFE, 32'h4433_2211, '0, 1'b0);
        applyStimulus(1'b0, 16'hFFFE, '0, 32'h4433_2211, 1'b0);
        waitDrain();
        checkOutput("wrap_cs_beats", 64'(cs_cycles - cs_before), 64'd9);
        checkOutput("wrap_mem_ffff", 64'(mem[16'hFFFF]), 64'h22);
        checkOutput("wrap_mem_0000", 64'(mem[16'h0000]), 64'h33);
        checkOutput("wrap_mem_0001", 64'(mem[16'h0001]), 64'h44);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
